isqrt_seq: RTL and testbench



---
 rtl/isqrt_pkg.sv | 25 ++
 rtl/isqrt_step.sv | 27 ++
 rtl/isqrt_seq.sv | 85 ++++++++
 tb/tb_isqrt_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/isqrt_pkg.sv
// Shared types and width helpers for the sequential integer square-root unit.
package isqrt_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int DEF_WIDTH = 16;

    function automatic int root_w(input int width);
        return width / 2;
    endfunction

    // Partial remainder carries two extra bits so t = {pm, 2 bits} never overflows.
    function automatic int pm_w(input int width);
        return width / 2 + 2;
    endfunction

    function automatic int iter_w(input int width);
        return (width / 2 > 1) ? $clog2(width / 2) : 1;
    endfunction

    localparam int RW  = root_w(DEF_WIDTH);
    localparam int PMW = pm_w(DEF_WIDTH);
    localparam int ITW = iter_w(DEF_WIDTH);

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit step: bring down two radicand bits, trial-subtract {pr,01}.
module isqrt_step
    import isqrt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [pm_w(WIDTH)-1:0]   pm,
    input  logic [root_w(WIDTH)-1:0] pr,
    input  logic [1:0]               bits,
    output logic [pm_w(WIDTH)-1:0]   pm_next,
    output logic [root_w(WIDTH)-1:0] pr_next
);
    localparam int SRW  = root_w(WIDTH);
    localparam int SPMW = pm_w(WIDTH);

    logic [SPMW+1:0] t;
    logic [SPMW+1:0] d;
    logic            ge;

    assign t  = {pm, bits};
    assign d  = {{(SPMW - SRW){1'b0}}, pr, 2'b01};
    assign ge = (t >= d);

    assign pm_next = ge ? SPMW'(t - d) : SPMW'(t);
    assign pr_next = {pr[SRW-2:0], ge};

endmodule

// File: rtl/isqrt_seq.sv
// Sequential isqrt: one root bit per clock; root/rem valid while done pulses.
module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     radicand,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH/2-1:0]   root,
    output logic [WIDTH/2:0]     rem
);
    localparam int LRW  = root_w(WIDTH);
    localparam int LPMW = pm_w(WIDTH);
    localparam int LITW = iter_w(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] rad;
    logic [LRW-1:0]   pr;
    logic [LPMW-1:0]  pm;
    logic [LITW-1:0]  iter;
    logic [LRW-1:0]   pr_next;
    logic [LPMW-1:0]  pm_next;

    isqrt_step #(.WIDTH(WIDTH)) u_step (
        .pm      (pm),
        .pr      (pr),
        .bits    (rad[WIDTH-1:WIDTH-2]),
        .pm_next (pm_next),
        .pr_next (pr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rad   <= '0;
            pr    <= '0;
            pm    <= '0;
            iter  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            root  <= '0;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rad   <= radicand;
                        pr    <= '0;
                        pm    <= '0;
                        iter  <= LITW'(LRW - 1);
                        root  <= '0;
                        rem   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rad <= rad << 2;
                    pr  <= pr_next;
                    pm  <= pm_next;
                    if (iter == '0) begin
                        // Publish the final step's result directly so it lines up with done.
                        root  <= pr_next;
                        rem   <= pm_next[LRW:0];
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        iter <= iter - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_seq.sv
// Randomized self-checking bench for isqrt_seq against a plain-arithmetic sqrt model.
module tb_isqrt_seq;
    localparam int WIDTH = 16;
    localparam int RW    = WIDTH / 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] radicand = '0;
    logic             busy;
    logic             done;
    logic [RW-1:0]    root;
    logic [RW:0]      rem;

    int checks = 0;
    int errors = 0;

    isqrt_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .radicand (radicand),
        .busy     (busy),
        .done     (done),
        .root     (root),
        .rem      (rem)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_root(input int v);
        int lo = 0, hi = (1 << RW) - 1, mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= v) lo = mid; else hi = mid - 1;
        end
        return lo;
    endfunction

    // Issue one operation, scramble radicand after acceptance, check latency/busy/result.
    task automatic do_op(input int v, input string tag);
        int n, r, busy_cnt;
        r = ref_root(v);
        @(negedge clk);
        start = 1'b1;
        radicand = WIDTH'(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        radicand = WIDTH'($urandom);
        n = 0;
        busy_cnt = 0;
        while (n < 30 && !done) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) busy_cnt++;
        check({tag, "_latency"}, n, RW);
        check({tag, "_busy_cycles"}, busy_cnt, RW + 1);
        check({tag, "_root"}, root, r);
        check({tag, "_rem"}, rem, v - r * r);
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, done, 0);
        check({tag, "_busy_drop"}, busy, 0);
        check({tag, "_root_hold"}, root, r);
    endtask

    initial begin
        int pulses, last, v, r;
        int first_gap;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_root", root, 0);
        check("rst_rem", rem, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(144, "r144");
        do_op(200, "r200");
        do_op(2, "r2");
        do_op(0, "r0");
        do_op(65535, "rmax");
        do_op(225, "sq225");

        // start held high: one result every RW+2 cycles, radicand ignored while busy
        @(negedge clk);
        start = 1'b1;
        radicand = 50;
        pulses = 0;
        last = -1;
        first_gap = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk);
            #1;
            if (busy) radicand = WIDTH'($urandom_range(1000, 60000));
            else radicand = 50;
            if (done) begin
                check("b2b_root", root, 7);
                check("b2b_rem", rem, 1);
                if (last >= 0) check("b2b_period", c - last, RW + 2);
                last = c;
                pulses++;
            end
        end
        check("b2b_pulses", (pulses >= 3) ? 1 : 0, 1);
        @(negedge clk);
        start = 1'b0;
        radicand = '0;
        repeat (RW + 3) @(posedge clk);

        // reset on the 4th CALC cycle aborts without a done pulse
        @(negedge clk);
        start = 1'b1;
        radicand = 1000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_root", root, 0);
        check("abort_rem", rem, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < RW + 4; c++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        do_op(1000, "r1000");

        // random sweep
        for (int i = 0; i < 2500; i++) begin
            v = (i % 50 == 0) ? (i / 50) * (i / 50) : int'($urandom_range(0, 65535));
            do_op(v, "rand");
            r = ref_root(v);
            check("rand_identity", 32'(root) * 32'(root) + 32'(rem), v);
            check("rand_rem_bound", (rem <= 2 * root) ? 1 : 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
